// File: rtl/adder_tree_pkg.sv
// Shared types and sizing for the adder-tree operand feeder.
package adder_tree_pkg;

    localparam int ADDER_WIDTH  = 17;
    localparam int N_LANES      = 8;
    localparam int SUM_LANES    = 4;
    localparam int SUM_WIDTH    = 18;
    localparam int TREE_LATENCY = 2;

    // Bits needed to index 0..n-1, never less than one bit.
    function automatic int cnt_w_f(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W  = cnt_w_f(N_LANES);
    localparam int WCNT_W = cnt_w_f(TREE_LATENCY + 1);
    localparam int REF_W  = ADDER_WIDTH + cnt_w_f(SUM_LANES);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel operand loader for the registered adder tree. Collects
// N_LANES operands, waits out the tree latency, captures the tree sum and
// flags any disagreement with a running reference over the summed lanes.
module adder_tree_feeder
    import adder_tree_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDER_WIDTH-1:0]         in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [N_LANES*ADDER_WIDTH-1:0] isum,
    input  logic [SUM_WIDTH-1:0]           tree_sum,
    output logic [SUM_WIDTH-1:0]           res_data,
    output logic                           res_mismatch,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic                           busy
);

    feeder_state_t          state_r;
    feeder_state_t          state_next_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_next_s;
    logic [WCNT_W-1:0]      wcnt_r;
    logic [REF_W-1:0]       ref_r;
    logic [ADDER_WIDTH-1:0] lanes_r [N_LANES];
    logic                   in_ready_r;
    logic                   busy_r;
    logic [SUM_WIDTH-1:0]   res_data_r;
    logic                   res_mismatch_r;
    logic                   res_valid_r;
    logic                   take_s;
    logic                   capture_s;
    logic                   res_hs_s;
    logic                   ref_lane_s;

    // Only the first SUM_LANES lanes reach the tree output, so only they feed the reference.
    assign ref_lane_s = ({1'b0, cnt_r} < (CNT_W + 1)'(SUM_LANES));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        take_s       = 1'b0;
        capture_s    = 1'b0;
        res_hs_s     = 1'b0;
        case (state_r)
            LOAD: begin
                if (in_valid && in_ready_r) begin
                    take_s = 1'b1;
                    if (cnt_r == CNT_W'(N_LANES - 1)) begin
                        cnt_next_s   = {CNT_W{1'b0}};
                        state_next_s = WAIT;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_W'(1);
                    end
                end else begin
                    take_s = 1'b0;
                end
            end
            WAIT: begin
                if (wcnt_r == WCNT_W'(TREE_LATENCY)) begin
                    capture_s    = 1'b1;
                    state_next_s = DONE;
                end else begin
                    capture_s    = 1'b0;
                end
            end
            DONE: begin
                if (res_valid_r && res_ready) begin
                    res_hs_s     = 1'b1;
                    state_next_s = LOAD;
                end else begin
                    res_hs_s     = 1'b0;
                end
            end
            default: begin
                state_next_s = LOAD;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Lane count, wait counter and registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            wcnt_r     <= {WCNT_W{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_next_s;
            wcnt_r     <= (state_r == WAIT) ? (wcnt_r + WCNT_W'(1)) : {WCNT_W{1'b0}};
            in_ready_r <= (state_next_s == LOAD);
            busy_r     <= (state_next_s != LOAD) || (cnt_next_s != {CNT_W{1'b0}});
        end
    end

    // Lane register file; lanes hold their values between batches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_LANES; k++) begin
                lanes_r[k] <= {ADDER_WIDTH{1'b0}};
            end
        end else if (take_s) begin
            lanes_r[cnt_r] <= in_data;
        end
    end

    // Running reference sum, cleared once the result has been consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_r <= {REF_W{1'b0}};
        end else if (take_s && ref_lane_s) begin
            ref_r <= ref_r + REF_W'(in_data);
        end else if (res_hs_s) begin
            ref_r <= {REF_W{1'b0}};
        end
    end

    // Result capture and hold until the consumer accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_r     <= {SUM_WIDTH{1'b0}};
            res_mismatch_r <= 1'b0;
            res_valid_r    <= 1'b0;
        end else if (capture_s) begin
            res_data_r     <= tree_sum;
            res_mismatch_r <= (tree_sum != ref_r[SUM_WIDTH-1:0]);
            res_valid_r    <= 1'b1;
        end else if (res_hs_s) begin
            res_valid_r    <= 1'b0;
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_isum
        assign isum[k*ADDER_WIDTH +: ADDER_WIDTH] = lanes_r[k];
    end

    assign in_ready     = in_ready_r;
    assign busy         = busy_r;
    assign res_data     = res_data_r;
    assign res_mismatch = res_mismatch_r;
    assign res_valid    = res_valid_r;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Bench for adder_tree_feeder with a two-level registered adder tree stub.
module tb_adder_tree_feeder;
    import adder_tree_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst;
    logic [ADDER_WIDTH-1:0]         in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic [N_LANES*ADDER_WIDTH-1:0] isum;
    logic [SUM_WIDTH-1:0]           tree_sum;
    logic [SUM_WIDTH-1:0]           res_data;
    logic                           res_mismatch;
    logic                           res_valid;
    logic                           res_ready;
    logic                           busy;

    logic [SUM_WIDTH-1:0]   s1_a, s1_b;
    logic [SUM_WIDTH-1:0]   bump;
    logic [ADDER_WIDTH-1:0] ops [N_LANES];
    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    adder_tree_feeder dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .isum(isum), .tree_sum(tree_sum),
        .res_data(res_data), .res_mismatch(res_mismatch), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy)
    );

    // Two-level registered adder tree over lanes 0..3, optional error injection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a     <= '0;
            s1_b     <= '0;
            tree_sum <= '0;
        end else begin
            s1_a     <= SUM_WIDTH'(isum[0*ADDER_WIDTH +: ADDER_WIDTH]) + SUM_WIDTH'(isum[1*ADDER_WIDTH +: ADDER_WIDTH]);
            s1_b     <= SUM_WIDTH'(isum[2*ADDER_WIDTH +: ADDER_WIDTH]) + SUM_WIDTH'(isum[3*ADDER_WIDTH +: ADDER_WIDTH]);
            tree_sum <= s1_a + s1_b + bump;
        end
    end

    // Expected result: plain sum of the first four operands, modulo 2^SUM_WIDTH.
    function automatic logic [SUM_WIDTH-1:0] model_sum(input logic [SUM_WIDTH-1:0] extra);
        longint s = 0;
        for (int i = 0; i < SUM_LANES; i++) s += longint'(ops[i]);
        s += longint'(extra);
        return SUM_WIDTH'(s % (longint'(1) << SUM_WIDTH));
    endfunction

    function automatic logic [ADDER_WIDTH-1:0] lane(input int k);
        return isum[k*ADDER_WIDTH +: ADDER_WIDTH];
    endfunction

    // Stream one operand, optionally preceded by random idle cycles.
    task automatic send_operand(input logic [ADDER_WIDTH-1:0] d, input int gap_pct);
        int n;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = ADDER_WIDTH'($urandom);
            @(negedge clk);
        end
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready got %0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_batch(input int gap_pct);
        for (int i = 0; i < N_LANES; i++) send_operand(ops[i], gap_pct);
    endtask

    // Wait for the result, hold it for 'hold' cycles, then accept it.
    task automatic collect(input logic [SUM_WIDTH-1:0] exp_d, input logic exp_m,
                           input int hold, input string tag, output int latency);
        res_ready = (hold == 0);
        latency = 0;
        while (!res_valid && latency < 50) begin
            @(negedge clk);
            latency++;
        end
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL %s_valid_timeout: got %0b required 1", tag, res_valid); end
        checks++;
        if (res_data !== exp_d) begin errors++; $display("FAIL %s_data: got %0h required %0h", tag, res_data, exp_d); end
        checks++;
        if (res_mismatch !== exp_m) begin errors++; $display("FAIL %s_mismatch: got %0b required %0b", tag, res_mismatch, exp_m); end
        in_valid = (hold > 0);
        in_data  = ADDER_WIDTH'($urandom);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_d || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold: valid %0b data %0h ready %0b required 1 %0h 0", tag, res_valid, res_data, in_ready, exp_d);
            end
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: valid %0b ready %0b required 0 1", tag, res_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b1; bump = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready %0b valid %0b busy %0b required 0 0 0", in_ready, res_valid, busy);
        end
        checks++;
        if (res_data !== '0 || res_mismatch !== 1'b0 || isum !== '0) begin
            errors++;
            $display("FAIL reset_data: res %0h mm %0b isum %0h required all 0", res_data, res_mismatch, isum);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < N_LANES; i++) ops[i] = ADDER_WIDTH'(i + 1);
        send_operand(ops[0], 0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b required 1", busy); end
        for (int i = 1; i < N_LANES; i++) send_operand(ops[i], 0);
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait: ready %0b valid %0b required 0 0", in_ready, res_valid);
        end
        checks++;
        if (lane(7) !== ADDER_WIDTH'(8)) begin errors++; $display("FAIL basic_lane7: got %0h required 8", lane(7)); end
        collect(model_sum('0), 1'b0, 0, "basic", lat);
        checks++;
        if (lat != TREE_LATENCY + 1) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, TREE_LATENCY + 1); end
        checks++;
        if (model_sum('0) !== SUM_WIDTH'(10)) begin errors++; $display("FAIL basic_model: got %0h required a", model_sum('0)); end
    endtask

    task automatic test_max();
        for (int i = 0; i < N_LANES; i++) ops[i] = {ADDER_WIDTH{1'b1}};
        send_batch(0);
        for (int k = 0; k < N_LANES; k++) begin
            checks++;
            if (lane(k) !== ops[k]) begin errors++; $display("FAIL max_lane%0d: got %0h required %0h", k, lane(k), ops[k]); end
        end
        collect(model_sum('0), 1'b0, 0, "max", lat);
    endtask

    task automatic test_hold();
        for (int i = 0; i < N_LANES; i++) ops[i] = ADDER_WIDTH'(i + 1);
        send_batch(0);
        collect(model_sum('0), 1'b0, 5, "hold", lat);
        for (int i = 0; i < N_LANES; i++) ops[i] = ADDER_WIDTH'(3 * i + 5);
        send_batch(0);
        collect(model_sum('0), 1'b0, 0, "after_hold", lat);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) send_operand(ADDER_WIDTH'(100 + i), 0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || isum !== '0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: ready %0b busy %0b isum %0h valid %0b required 0 0 0 0", in_ready, busy, isum, res_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N_LANES; i++) ops[i] = (i < 4) ? ADDER_WIDTH'(2) : ADDER_WIDTH'(0);
        send_operand(ops[0], 0);
        checks++;
        if (lane(0) !== ADDER_WIDTH'(2) || lane(1) !== ADDER_WIDTH'(0)) begin
            errors++;
            $display("FAIL midrst_lane0: lane0 %0h lane1 %0h required 2 0", lane(0), lane(1));
        end
        for (int i = 1; i < N_LANES; i++) send_operand(ops[i], 0);
        collect(SUM_WIDTH'(8), 1'b0, 0, "midrst", lat);
    endtask

    task automatic test_mismatch();
        for (int i = 0; i < N_LANES; i++) ops[i] = ADDER_WIDTH'(i + 1);
        bump = SUM_WIDTH'(1);
        send_batch(0);
        collect(SUM_WIDTH'(11), 1'b1, 0, "mismatch", lat);
        bump = '0;
    endtask

    task automatic test_random();
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < N_LANES; i++) ops[i] = ADDER_WIDTH'($urandom);
            send_batch(50);
            collect(model_sum('0), 1'b0, int'($urandom_range(2)), "random", lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_hold();
        test_mid_reset();
        test_mismatch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
